load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_load_align.sv | 23 ++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, and
// the byte-lane masks and misalignment rule.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Size 3 is treated as a misaligned access so it never touches memory.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between a core and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_misaligned
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/half out of a memory word and sign/zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    result = rdata;
    case (size)
      SZ_B: result = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H: result = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligned accesses go to data memory in the
// accept cycle; loads respond two cycles later, stores and faults one cycle later.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = 32768
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [31:0]        addrD,
  output logic               renD,
  input  logic [31:0]        rdataD,
  output logic               wenD,
  output logic [31:0]        wdataD,
  output logic [3:0]         MaskD,
  output logic [31:0]        cnt_load,
  output logic [31:0]        cnt_store,
  output logic [31:0]        cnt_misaligned
);
  state_e      state;
  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [31:0] ld_result;
  logic        accept;
  logic        mis;
  logic [1:0]  off;
  logic [3:0]  lane_mask;

  assign off = bus.req_addr[1:0];
  assign mis = misaligned(bus.req_size, off);

  assign bus.req_ready = !reset &&
                         ((state == IDLE) || ((state == RESP) && bus.resp_ready));
  assign accept = bus.req_valid && bus.req_ready;

  assign addrD = {bus.req_addr[31:2], 2'b00};
  assign renD  = accept && !bus.req_store && !mis;
  assign wenD  = accept &&  bus.req_store && !mis;

  always_comb begin
    lane_mask = MASK_W;
    wdataD    = bus.req_wdata;
    case (bus.req_size)
      SZ_B: begin
        lane_mask = MASK_B << off;
        wdataD    = {4{bus.req_wdata[7:0]}};
      end
      SZ_H: begin
        lane_mask = MASK_H << {off[1], 1'b0};
        wdataD    = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign MaskD = wenD ? lane_mask : 4'b0000;

  load_align u_align (
    .rdata  (rdataD),
    .off    (ld_off),
    .size   (ld_size),
    .uns    (ld_uns),
    .result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= 32'd0;
      bus.resp_misaligned <= 1'b0;
      ld_off              <= 2'd0;
      ld_size             <= 2'd0;
      ld_uns              <= 1'b0;
      cnt_load            <= 32'd0;
      cnt_store           <= 32'd0;
      cnt_misaligned      <= 32'd0;
    end else begin
      case (state)
        LOAD_WAIT: begin
          state               <= RESP;
          bus.resp_valid      <= 1'b1;
          bus.resp_rdata      <= ld_result;
          bus.resp_misaligned <= 1'b0;
        end
        default: begin
          // IDLE, or RESP being drained this cycle; a stalled RESP holds everything.
          if (state == IDLE || bus.resp_ready) begin
            if (accept) begin
              if (mis) begin
                state               <= RESP;
                bus.resp_valid      <= 1'b1;
                bus.resp_rdata      <= 32'd0;
                bus.resp_misaligned <= 1'b1;
                cnt_misaligned      <= cnt_misaligned + 32'd1;
              end else if (bus.req_store) begin
                state               <= RESP;
                bus.resp_valid      <= 1'b1;
                bus.resp_rdata      <= 32'd0;
                bus.resp_misaligned <= 1'b0;
                cnt_store           <= cnt_store + 32'd1;
              end else begin
                state               <= LOAD_WAIT;
                bus.resp_valid      <= 1'b0;
                bus.resp_misaligned <= 1'b0;
                ld_off              <= off;
                ld_size             <= bus.req_size;
                ld_uns              <= bus.req_unsigned;
                cnt_load            <= cnt_load + 32'd1;
              end
            end else begin
              state               <= IDLE;
              bus.resp_valid      <= 1'b0;
              bus.resp_misaligned <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-wide memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addrD, rdataD, wdataD;
  logic        renD, wenD;
  logic [3:0]  MaskD;
  logic [31:0] cnt_load, cnt_store, cnt_misaligned;

  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_dat;

  int n_vec = 0;
  int n_err = 0;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .addrD(addrD), .renD(renD), .rdataD(rdataD), .wenD(wenD),
    .wdataD(wdataD), .MaskD(MaskD),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_misaligned(cnt_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (renD) rdataD <= mem[addrD[5:2]];
    if (wenD)
      for (int b = 0; b < 4; b++)
        if (MaskD[b]) mem[addrD[5:2]][8*b +: 8] <= wdataD[8*b +: 8];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    #1;
  endtask

  task automatic idle_req;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
    pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
    step;
    pre_we = 1'b0;
  endtask

  // Issue a load and check the response arrives exactly at T+2.
  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, sz, uns, addr, 32'd0);
    chk({tag, "_renD"}, {31'd0, renD}, 32'd1);
    step;
    idle_req;
    #1;
    chk({tag, "_wait_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    step;
    chk({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    step;
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
    rdataD = '0;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    step;
    preload(4'd0, 32'h8077F0AA);
    preload(4'd1, 32'h11223344);
    bus.req_valid = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_renD", {31'd0, renD}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_cnt_load", cnt_load, 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    load_chk("lb_s_1", 2'd0, 1'b0, 32'h1, 32'hFFFFFFF0);
    load_chk("lbu_3", 2'd0, 1'b1, 32'h3, 32'h00000080);
    preload(4'd0, 32'h80011234);
    load_chk("lh_s_2", 2'd1, 1'b0, 32'h2, 32'hFFFF8001);
    load_chk("lw_0", 2'd2, 1'b0, 32'h0, 32'h80011234);
    load_chk("lbu_0", 2'd0, 1'b1, 32'h0, 32'h00000034);
    chk("cnt_load_5", cnt_load, 32'd5);

    // byte store into lane 2 of word 1
    drive(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000005A);
    chk("sb_wenD", {31'd0, wenD}, 32'd1);
    chk("sb_renD", {31'd0, renD}, 32'd0);
    chk("sb_mask", {28'd0, MaskD}, 32'h4);
    chk("sb_wdata", wdataD, 32'h5A5A5A5A);
    chk("sb_addrD", addrD, 32'h4);
    step;
    idle_req;
    #1;
    chk("sb_wen_once", {31'd0, wenD}, 32'd0);
    chk("sb_mask_off", {28'd0, MaskD}, 32'h0);
    chk("sb_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("sb_resp_rdata", bus.resp_rdata, 32'd0);
    chk("sb_resp_mis", {31'd0, bus.resp_misaligned}, 32'd0);
    chk("cnt_store_1", cnt_store, 32'd1);
    step;
    load_chk("lw_4_after_sb", 2'd2, 1'b0, 32'h4, 32'h115A3344);

    // half store upper lanes
    drive(1'b1, 2'd1, 1'b0, 32'hE, 32'hABCD9876);
    chk("sh_mask", {28'd0, MaskD}, 32'hC);
    chk("sh_wdata", wdataD, 32'h98769876);
    step;
    idle_req;
    step;

    // misaligned word load
    drive(1'b0, 2'd2, 1'b0, 32'h2, 32'd0);
    chk("mis_renD", {31'd0, renD}, 32'd0);
    chk("mis_wenD", {31'd0, wenD}, 32'd0);
    step;
    idle_req;
    #1;
    chk("mis_renD_t1", {31'd0, renD}, 32'd0);
    chk("mis_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_flag", {31'd0, bus.resp_misaligned}, 32'd1);
    chk("mis_rdata", bus.resp_rdata, 32'd0);
    chk("cnt_mis_1", cnt_misaligned, 32'd1);
    chk("cnt_load_mis", cnt_load, 32'd6);
    step;
    drive(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF);
    chk("sz3_wenD", {31'd0, wenD}, 32'd0);
    step;
    idle_req;
    #1;
    chk("sz3_flag", {31'd0, bus.resp_misaligned}, 32'd1);
    chk("cnt_mis_2", cnt_misaligned, 32'd2);
    step;

    // backpressure then back-to-back accept
    bus.resp_ready = 1'b0;
    drive(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    chk("sw_mask", {28'd0, MaskD}, 32'hF);
    chk("sw_wdata", wdataD, 32'hDEADBEEF);
    step;
    drive(1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_renD", {31'd0, renD}, 32'd0);
      chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_rdata", bus.resp_rdata, 32'd0);
      chk("bp_mis", {31'd0, bus.resp_misaligned}, 32'd0);
      step;
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_renD", {31'd0, renD}, 32'd1);
    step;
    idle_req;
    #1;
    chk("b2b_wait_valid", {31'd0, bus.resp_valid}, 32'd0);
    step;
    chk("b2b_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_rdata", bus.resp_rdata, 32'hDEADBEEF);
    chk("cnt_store_3", cnt_store, 32'd3);
    chk("cnt_load_7", cnt_load, 32'd7);
    step;
    load_chk("lw_c_after_sh", 2'd2, 1'b0, 32'hC, 32'h98760000);

    // reset while a load is outstanding
    drive(1'b0, 2'd0, 1'b0, 32'h0, 32'd0);
    step;
    idle_req;
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    chk("rlw_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rlw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rlw_cnt_load", cnt_load, 32'd0);
    chk("rlw_cnt_store", cnt_store, 32'd0);
    chk("rlw_cnt_mis", cnt_misaligned, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step;
      chk("rlw_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    load_chk("lw_4_kept", 2'd2, 1'b0, 32'h4, 32'h115A3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
